// File: rtl/unsigned_16by8_seq_div_if.sv
// Handshake and data bundle for the sequential 2N-by-N unsigned divider.
// The master side supplies operands and consumes results; the slave side
// is the divider itself.
interface unsigned_16by8_seq_div_if #(
    parameter int N = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2*N-1:0]   z;
    logic [N-1:0]     y;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     q;
    logic [N-1:0]     r;
    logic             dbz;
    logic             ovf;

    modport master (
        output in_valid, z, y, out_ready,
        input  in_ready, out_valid, q, r, dbz, ovf
    );

    modport slave (
        input  in_valid, z, y, out_ready,
        output in_ready, out_valid, q, r, dbz, ovf
    );
endinterface

// File: rtl/unsigned_16by8_seq_div.sv
// Sequential unsigned restoring divider: 2N-bit dividend by N-bit divisor,
// one quotient bit per clock, valid/ready on both sides.
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero and quotient-overflow
// operations skip the iteration and report one clock after acceptance.
// Without it every operation takes exactly N clocks.
module unsigned_16by8_seq_div #(
    parameter int N = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    unsigned_16by8_seq_div_if.slave  bus
);
    localparam int            CW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_r, state_s;
    logic [CW-1:0]  cnt_r, cnt_s;
    logic [N:0]     p_r, p_s;          // partial remainder, one guard bit
    logic [N-1:0]   s_r, s_s;          // dividend low half, becomes quotient
    logic [N-1:0]   y_r, y_s;
    logic           err_dbz_r, err_dbz_s;
    logic           err_ovf_r, err_ovf_s;
    logic [N-1:0]   q_r, q_s;
    logic [N-1:0]   r_r, r_s;
    logic           dbz_r, dbz_s;
    logic           ovf_r, ovf_s;
    logic           in_ready_r, in_ready_s;
    logic           out_valid_r, out_valid_s;

    logic [N:0]     t_s;               // shifted trial remainder
    logic           ge_s;              // trial remainder >= divisor
    logic [N:0]     p_step_s;
    logic [N-1:0]   s_step_s;
    logic           last_s;

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.q         = q_r;
    assign bus.r         = r_r;
    assign bus.dbz       = dbz_r;
    assign bus.ovf       = ovf_r;

    // Next-state, restoring-step datapath and result selection.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        p_s         = p_r;
        s_s         = s_r;
        y_s         = y_r;
        err_dbz_s   = err_dbz_r;
        err_ovf_s   = err_ovf_r;
        q_s         = q_r;
        r_s         = r_r;
        dbz_s       = dbz_r;
        ovf_s       = ovf_r;

        t_s  = {p_r[N-1:0], s_r[N-1]};
        ge_s = (t_s >= {1'b0, y_r});
        if (ge_s) begin
            p_step_s = t_s - {1'b0, y_r};
        end else begin
            p_step_s = t_s;
        end
        s_step_s = {s_r[N-2:0], ge_s};

`ifdef DIV_EARLY_OUT_EN
        last_s = (cnt_r == CNT_LAST) || err_dbz_r || err_ovf_r;
`else
        last_s = (cnt_r == CNT_LAST);
`endif

        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    y_s       = bus.y;
                    p_s       = {1'b0, bus.z[2*N-1:N]};
                    s_s       = bus.z[N-1:0];
                    err_dbz_s = (bus.y == {N{1'b0}});
                    err_ovf_s = (bus.y != {N{1'b0}}) && (bus.z[2*N-1:N] >= bus.y);
                    cnt_s     = CNT_ZERO;
                    state_s   = CALC;
                end else begin
                    state_s   = IDLE;
                end
            end
            CALC: begin
                p_s   = p_step_s;
                s_s   = s_step_s;
                cnt_s = cnt_r + CNT_ONE;
                if (last_s) begin
                    state_s = DONE;
                    cnt_s   = CNT_ZERO;
                    if (err_dbz_r) begin
                        q_s   = {N{1'b1}};
                        r_s   = {N{1'b1}};
                        dbz_s = 1'b1;
                        ovf_s = 1'b0;
                    end else if (err_ovf_r) begin
                        q_s   = {N{1'b1}};
                        r_s   = {N{1'b1}};
                        dbz_s = 1'b0;
                        ovf_s = 1'b1;
                    end else begin
                        q_s   = s_step_s;
                        r_s   = p_step_s[N-1:0];
                        dbz_s = 1'b0;
                        ovf_s = 1'b0;
                    end
                end else begin
                    state_s = CALC;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase

        in_ready_s  = (state_s == IDLE);
        out_valid_s = (state_s == DONE);
    end

    // State, datapath and registered handshake/result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= CNT_ZERO;
            p_r         <= {(N+1){1'b0}};
            s_r         <= {N{1'b0}};
            y_r         <= {N{1'b0}};
            err_dbz_r   <= 1'b0;
            err_ovf_r   <= 1'b0;
            q_r         <= {N{1'b0}};
            r_r         <= {N{1'b0}};
            dbz_r       <= 1'b0;
            ovf_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            p_r         <= p_s;
            s_r         <= s_s;
            y_r         <= y_s;
            err_dbz_r   <= err_dbz_s;
            err_ovf_r   <= err_ovf_s;
            q_r         <= q_s;
            r_r         <= r_s;
            dbz_r       <= dbz_s;
            ovf_r       <= ovf_s;
            in_ready_r  <= in_ready_s;
            out_valid_r <= out_valid_s;
        end
    end
endmodule
